mdu_seq_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the single-cycle EX-stage ALU.
- Iterative shift-add MUL and restoring-divide DIVU/REMU run over XLEN cycles instead of a combinational multiplier.
- Drives a stall to the hazard unit while busy and returns one result to the EX/MEM boundary with a one-cycle done pulse.
- Flushable by branch/jump redirect.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_iter_step.sv | 51 +++++
 rtl/mdu_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, default width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef logic [1:0] mdu_op_t;

    localparam mdu_op_t MDU_MUL  = 2'b00;   // low XLEN bits of A*B
    localparam mdu_op_t MDU_DIVU = 2'b01;   // unsigned quotient
    localparam mdu_op_t MDU_REMU = 2'b10;   // unsigned remainder
    localparam mdu_op_t MDU_RSVD = 2'b11;   // reserved, returns zero

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of shift-add multiply or restoring unsigned divide.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer decides when the next values are captured.
//
// Ports:
//   op_i              operation; anything other than MUL is treated as a divide step
//   acc_i / acc_o     MUL accumulator, or divide partial remainder
//   sh_i  / sh_o      MUL multiplicand (shifts left), or divide quotient/dividend (shifts left)
//   opb_i / opb_o     MUL multiplier (shifts right), or divisor (passes through)
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  mdu_op_t         op_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] sh_i,
    input  logic [XLEN-1:0] opb_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] sh_o,
    output logic [XLEN-1:0] opb_o
);

    // Dropping the remainder MSB is safe: before the last step the partial
    // remainder is built from at most XLEN-1 dividend bits, so its top bit is 0.
    logic [XLEN-1:0] rem_sh;
    assign rem_sh = {acc_i[XLEN-2:0], sh_i[XLEN-1]};

    always_comb begin
        acc_o = acc_i;
        sh_o  = sh_i;
        opb_o = opb_i;
        if (op_i == MDU_MUL) begin
            if (opb_i[0]) begin
                acc_o = acc_i + sh_i;
            end
            sh_o  = sh_i << 1;
            opb_o = opb_i >> 1;
        end else begin
            // The dividend drains out of the top of sh while quotient bits
            // fill in from the bottom.
            sh_o  = sh_i << 1;
            acc_o = rem_sh;
            if (rem_sh >= opb_i) begin
                acc_o   = rem_sh - opb_i;
                sh_o[0] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle MUL/DIVU/REMU sequencer beside the EX-stage ALU.
// Latency: done_o XLEN+1 cycles after the start cycle; 1 cycle for divide-by-zero or reserved op.
// Backpressure: stall_o holds IF/ID/EX while busy or while accepting; flush_i aborts at any point.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-low reset
//   start_i     request, sampled only in IDLE or DONE
//   op_i        00 MUL, 01 DIVU, 10 REMU, 11 reserved
//   rs1_data_i  operand A (multiplicand / dividend)
//   rs2_data_i  operand B (multiplier / divisor)
//   flush_i     abort; wins over start_i
//   stall_o     combinational pipeline hold
//   done_o      one-cycle result-valid pulse
//   result_o    result, stable until the next completion
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic [1:0]      state_q,  state_d;
    mdu_op_t         op_q,     op_d;
    logic [XLEN-1:0] acc_q,    acc_d;     // MUL accumulator / divide remainder
    logic [XLEN-1:0] sh_q,     sh_d;      // multiplicand / quotient
    logic [XLEN-1:0] opb_q,    opb_d;     // multiplier / divisor
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] step_acc;
    logic [XLEN-1:0] step_sh;
    logic [XLEN-1:0] step_opb;

    logic accept;
    logic fast_path;
    logic [XLEN-1:0] fast_result;

    mdu_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .sh_i  (sh_q),
        .opb_i (opb_q),
        .acc_o (step_acc),
        .sh_o  (step_sh),
        .opb_o (step_opb)
    );

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i && !flush_i;

    // Ops whose answer is known without iterating.
    assign fast_path = (op_i == MDU_RSVD) ||
                       (((op_i == MDU_DIVU) || (op_i == MDU_REMU)) && (rs2_data_i == '0));

    always_comb begin
        case (op_i)
            MDU_DIVU: fast_result = '1;
            MDU_REMU: fast_result = rs1_data_i;
            default:  fast_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        count_d  = count_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else if (accept) begin
            op_d    = op_i;
            acc_d   = '0;
            sh_d    = rs1_data_i;
            opb_d   = rs2_data_i;
            count_d = '0;
            if (fast_path) begin
                state_d  = S_DONE;
                result_d = fast_result;
            end else begin
                state_d  = S_BUSY;
            end
        end else if (state_q == S_BUSY) begin
            acc_d   = step_acc;
            sh_d    = step_sh;
            opb_d   = step_opb;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
                state_d = S_DONE;
                case (op_q)
                    MDU_DIVU: result_d = step_sh;
                    default:  result_d = step_acc;   // MUL product or REMU remainder
                endcase
            end
        end else begin
            // IDLE without a start, DONE without a follow-on, or an illegal code.
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= MDU_MUL;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Low in DONE unless a new op is taken, so EX/MEM captures result_o that cycle.
    assign stall_o  = rst_i && ((state_q == S_BUSY) || accept);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed bench for mdu_seq_ctrl with hand-computed expected results and latencies.
// Latency: drives one op at a time, back-to-back where noted.
// Backpressure: observes stall_o each cycle.
module tb_mdu_seq_ctrl;

    localparam int XLEN = 32;

    logic            clk_i;
    logic            rst_i;
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_seq_ctrl #(
        .XLEN (XLEN)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called in the accept cycle with start_i already driven. Drops start_i
    // after the edge (except pulsing junk at cycle pulse_at) and returns the
    // cycle count to done_o plus how many pre-done cycles had stall_o low.
    task automatic wait_done(input int pulse_at, output int lat, output int stall_low);
        lat       = 0;
        stall_low = 0;
        do begin
            if (!stall_o) stall_low++;
            tick();
            lat++;
            if (lat == pulse_at) begin
                start_i    = 1'b1;
                op_i       = 2'b01;
                rs1_data_i = 32'd1;
                rs2_data_i = 32'd0;
            end else begin
                start_i    = 1'b0;
                rs1_data_i = 32'hDEAD_BEEF;
                rs2_data_i = 32'h0000_0000;
            end
            #1;
        end while (!done_o && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stall_low;
        start_i    = 1'b1;
        op_i       = op;
        rs1_data_i = a;
        rs2_data_i = b;
        #1;
        wait_done(-1, lat, stall_low);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " stall gaps"}, stall_low, 0);
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " stall in done"}, stall_o, 1'b0);
        tick();
        chk({tag, " done pulse width"}, done_o, 1'b0);
    endtask

    initial begin
        int lat;
        int stall_low;
        int bad;

        rst_i      = 1'b0;
        start_i    = 1'b1;   // must not raise stall_o while in reset
        op_i       = 2'b00;
        rs1_data_i = 32'd1;
        rs2_data_i = 32'd1;
        flush_i    = 1'b0;
        tick();
        tick();
        chk("reset stall", stall_o, 1'b0);
        chk("reset done", done_o, 1'b0);
        chk("reset result", result_o, 32'd0);
        start_i = 1'b0;
        #1;
        rst_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stall_o || done_o) bad++;
        end
        chk("idle quiet", bad, 0);
        chk("idle result", result_o, 32'd0);

        // MUL, with a hold check out to T+40.
        run_op("mul 7*6", 2'b00, 32'd7, 32'd6, 32'd42, 33);
        for (int i = 0; i < 6; i++) tick();
        chk("mul hold T+40", result_o, 32'd42);
        chk("mul hold done", done_o, 1'b0);
        run_op("mul ffffffff*2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
        run_op("mul overflow", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);

        // Divide.
        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("divu big divisor", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        run_op("remu big divisor", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);

        // Fast path.
        run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 1);
        run_op("reserved op", 2'b11, 32'd5, 32'd9, 32'd0, 1);
        run_op("divu 100/7 again", 2'b01, 32'd100, 32'd7, 32'd14, 33);

        // Flush mid-op: MUL 3*3 started at T, flush at T+10.
        start_i    = 1'b1;
        op_i       = 2'b00;
        rs1_data_i = 32'd3;
        rs2_data_i = 32'd3;
        #1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush_i = 1'b1;
        #1;
        chk("flush cycle stall", stall_o, 1'b1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush T+11 stall", stall_o, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall_o || done_o) bad++;
            tick();
        end
        chk("flush no done/stall", bad, 0);
        chk("flush result kept", result_o, 32'd14);
        run_op("mul 3*3 after flush", 2'b00, 32'd3, 32'd3, 32'd9, 33);

        // start and flush together in IDLE.
        start_i    = 1'b1;
        flush_i    = 1'b1;
        op_i       = 2'b00;
        rs1_data_i = 32'd2;
        rs2_data_i = 32'd2;
        #1;
        chk("start+flush stall", stall_o, 1'b0);
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall_o || done_o) bad++;
            tick();
        end
        chk("start+flush ignored", bad, 0);
        chk("start+flush result", result_o, 32'd9);

        // Back-to-back: DIVU 9/2 issued in the DONE cycle of MUL 5*5,
        // with a fast-path-looking start pulsed during BUSY.
        start_i    = 1'b1;
        op_i       = 2'b00;
        rs1_data_i = 32'd5;
        rs2_data_i = 32'd5;
        #1;
        wait_done(-1, lat, stall_low);
        chk("b2b mul latency", lat, 33);
        chk("b2b mul done", done_o, 1'b1);
        chk("b2b mul result", result_o, 32'd25);
        start_i    = 1'b1;
        op_i       = 2'b01;
        rs1_data_i = 32'd9;
        rs2_data_i = 32'd2;
        #1;
        chk("b2b stall in done", stall_o, 1'b1);
        chk("b2b result before edge", result_o, 32'd25);
        wait_done(5, lat, stall_low);
        chk("b2b divu latency", lat, 33);
        chk("b2b divu stall gaps", stall_low, 0);
        chk("b2b divu result", result_o, 32'd4);
        tick();
        chk("b2b final done", done_o, 1'b0);
        chk("b2b final stall", stall_o, 1'b0);
        chk("b2b final result", result_o, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
